craps_ctrl: RTL and testbench
=============================

# craps_ctrl

Game controller that sequences two die roller instances into a craps round. It watches each roller's `choose` level and treats a rising edge as a completed roll. It then sums the two latched face values and runs the come-out/point state machine. It drives win/lose indicators, the established point and the last sum to the display logic.

## Interface
- `CNT_W`, default 4: width of the per-round roll counter (saturating).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `die_a`  in  3  face value from roller A; legal range 1..6.
- `die_b`  in  3  face value from roller B; legal range 1..6.
- `choose`  in  1  level from the rollers: high while the dice are settled (button released, value nonzero).
- `new_game`  in  1  single-cycle pulse that starts a new round.
- `win`  out  1  high while in WIN.
- `lose`  out  1  high while in LOSE.
- `point`  out  4  established point (4,5,6,8,9,10); 0 when no point.
- `last_sum`  out  4  sum of the most recently accepted roll; 0 after reset or new game.
- `rolls`  out  CNT_W  accepted rolls this round; saturates at all-ones.
- `wins`, `losses`  out  8 each  session tallies (see Configuration).

## Operation
- Roll event: `choose & ~choose_q`, where `choose_q` is `choose` registered one cycle.
- Acceptance: a roll event is accepted only if both `die_a` and `die_b` are in 1..6. Otherwise it is ignored: no state, sum or counter change.
- Sum: `die_a + die_b` zero-extended to 4 bits; range 2..12, no overflow.
- States:
  - COME_OUT: accepted sum 7 or 11 → WIN. Sum 2, 3 or 12 → LOSE. Any other sum → latch `point` = sum, go to POINT.
  - POINT: sum == `point` → WIN. Sum == 7 → LOSE. Else remain in POINT.
  - WIN, LOSE: terminal. Roll events are ignored and `last_sum`/`rolls` are frozen.
- `new_game`, in any state: go to COME_OUT and clear `point`, `last_sum` and `rolls`. Tallies are kept.
- Simultaneous `new_game` and roll event: `new_game` wins and the roll is discarded. A roll needs a fresh rising edge of `choose` after that.
- Every accepted roll in COME_OUT or POINT updates `last_sum` and increments `rolls`, saturating.

## Timing
- Reset values:
  - state = COME_OUT
  - `win` = `lose` = 0
  - `point` = `last_sum` = 0
  - `rolls` = 0
  - `wins` = `losses` = 0
  - `choose_q` = 1, so a `choose` already high at reset release is not a roll.
- Latency: an accepted roll changes the outputs on the same rising edge on which `choose` is first sampled high. The new values are visible one cycle after `choose` rises.
- `win` and `lose` are decoded from registered state: glitch-free and never both high.
- Dice inputs are sampled only on the event cycle. They may change freely afterwards.
- Reset mid-round: on the next edge, all registers take their reset values, tallies included.

## Configuration
- `CRAPS_STATS_EN` defined:
  - `wins` increments on each entry to WIN.
  - `losses` increments on each entry to LOSE.
  - Both are 8-bit and saturate at 255.
- Not defined: `wins` and `losses` are tied to 0 and the counters are not synthesized. Ports remain.

## Structure
- `craps_pkg`:
  - typedef `craps_state_t` enum {COME_OUT, POINT, WIN, LOSE}
  - localparams `SUM_W` = 4, `NATURAL_7` = 7, `NATURAL_11` = 11
  - function `is_craps(sum)` for 2/3/12
- Sub-module `roll_edge`: the `choose_q` register (reset value 1) plus the rising-edge and die-range qualification. It outputs `roll_ok` and `sum`.

## Test plan
- Reset, `choose` low; `choose` rises with dice 3,4 → next cycle `win` = 1, `last_sum` = 7, `rolls` = 1.
- Come-out with dice 1,1 → `lose` = 1, `point` = 0, `last_sum` = 2.
- Come-out with 2,4 → `point` = 6; roll 5,5 → stays in POINT, `rolls` = 2; roll 3,3 → `win` = 1; further rolls leave `last_sum` = 6, `rolls` = 3.
- With `point` = 8, roll 3,4 → `lose` = 1; `new_game` pulse → `point` = 0, `last_sum` = 0, `rolls` = 0, state COME_OUT; `losses` = 1 with `CRAPS_STATS_EN`, else 0.
- Roll with `die_a` = 0, then with `die_b` = 7 → no output change. `choose` held high for 10 cycles → counted once.
- `new_game` asserted on the cycle `choose` rises with 5,6 → COME_OUT, `last_sum` = 0. `choose` high at reset release → no roll counted.

Source files
------------

// File: rtl/craps_pkg.sv
// Shared types and constants for the craps round controller.
// The state encoding, sum width and the natural/craps sum decode live here
// so the controller and its roll qualifier agree on them.
package craps_pkg;

    typedef enum logic [1:0] {
        COME_OUT = 2'd0,
        POINT    = 2'd1,
        WIN      = 2'd2,
        LOSE     = 2'd3
    } craps_state_t;

    localparam int SUM_W = 4;

    localparam logic [SUM_W-1:0] NATURAL_7  = 4'd7;
    localparam logic [SUM_W-1:0] NATURAL_11 = 4'd11;

    // A come-out sum of 2, 3 or 12 loses the round immediately.
    function automatic logic is_craps(input logic [SUM_W-1:0] sum);
        return (sum == 4'd2) || (sum == 4'd3) || (sum == 4'd12);
    endfunction

endpackage

// File: rtl/craps_roll_edge.sv
// Roll qualifier for the craps controller.
// Registers the rollers' choose level, detects its rising edge and only
// reports a roll when both dice show a legal face (1..6). The registered
// level comes out of reset high so a choose already high at reset release
// is not mistaken for a fresh roll.
import craps_pkg::*;

module roll_edge (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_choose,
    input  logic [2:0]       i_die_a,
    input  logic [2:0]       i_die_b,
    output logic             o_roll_ok,
    output logic [SUM_W-1:0] o_sum
);

    logic r_choose_q;
    logic w_rise;
    logic w_die_a_ok;
    logic w_die_b_ok;

    // Delay choose by one cycle so its rising edge can be found.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_choose_q <= 1'b1;
        end else begin
            r_choose_q <= i_choose;
        end
    end

    assign w_rise     = i_choose & ~r_choose_q;
    assign w_die_a_ok = (i_die_a != 3'd0) && (i_die_a <= 3'd6);
    assign w_die_b_ok = (i_die_b != 3'd0) && (i_die_b <= 3'd6);

    assign o_roll_ok = w_rise & w_die_a_ok & w_die_b_ok;
    assign o_sum     = {1'b0, i_die_a} + {1'b0, i_die_b};

endmodule

// File: rtl/craps_ctrl.sv
// Craps round controller.
// Turns qualified rolls from two die rollers into the come-out / point
// game, and drives win/lose, the established point, the last accepted sum
// and the per-round roll count to the display logic.
// Optional feature: define CRAPS_STATS_EN to build the saturating session
// win/loss tallies; without it those outputs are tied to zero.
import craps_pkg::*;

module craps_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_die_a,
    input  logic [2:0]       i_die_b,
    input  logic             i_choose,
    input  logic             i_new_game,
    output logic             o_win,
    output logic             o_lose,
    output logic [3:0]       o_point,
    output logic [3:0]       o_last_sum,
    output logic [CNT_W-1:0] o_rolls,
    output logic [7:0]       o_wins,
    output logic [7:0]       o_losses
);

    craps_state_t     r_state;
    craps_state_t     w_state_next;
    logic [SUM_W-1:0] r_point;
    logic [SUM_W-1:0] w_point_next;
    logic [SUM_W-1:0] r_last_sum;
    logic [SUM_W-1:0] w_last_sum_next;
    logic [CNT_W-1:0] r_rolls;
    logic [CNT_W-1:0] w_rolls_next;

    logic             w_roll_ok;
    logic [SUM_W-1:0] w_sum;

    roll_edge u_roll_edge (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_choose  (i_choose),
        .i_die_a   (i_die_a),
        .i_die_b   (i_die_b),
        .o_roll_ok (w_roll_ok),
        .o_sum     (w_sum)
    );

    // Hold the game state, point, last sum and roll count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= COME_OUT;
            r_point    <= '0;
            r_last_sum <= '0;
            r_rolls    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_point    <= w_point_next;
            r_last_sum <= w_last_sum_next;
            r_rolls    <= w_rolls_next;
        end
    end

    // Next-state decode: new_game overrides any roll; terminal states ignore rolls.
    always_comb begin
        w_state_next    = r_state;
        w_point_next    = r_point;
        w_last_sum_next = r_last_sum;
        w_rolls_next    = r_rolls;
        if (i_new_game) begin
            w_state_next    = COME_OUT;
            w_point_next    = '0;
            w_last_sum_next = '0;
            w_rolls_next    = '0;
        end else if (w_roll_ok && ((r_state == COME_OUT) || (r_state == POINT))) begin
            w_last_sum_next = w_sum;
            if (r_rolls != {CNT_W{1'b1}}) begin
                w_rolls_next = r_rolls + CNT_W'(1);
            end
            case (r_state)
                COME_OUT: begin
                    if ((w_sum == NATURAL_7) || (w_sum == NATURAL_11)) begin
                        w_state_next = WIN;
                    end else if (is_craps(w_sum)) begin
                        w_state_next = LOSE;
                    end else begin
                        w_state_next = POINT;
                        w_point_next = w_sum;
                    end
                end
                POINT: begin
                    if (w_sum == r_point) begin
                        w_state_next = WIN;
                    end else if (w_sum == NATURAL_7) begin
                        w_state_next = LOSE;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    assign o_win      = (r_state == WIN);
    assign o_lose     = (r_state == LOSE);
    assign o_point    = r_point;
    assign o_last_sum = r_last_sum;
    assign o_rolls    = r_rolls;

`ifdef CRAPS_STATS_EN
    logic [7:0] r_wins;
    logic [7:0] r_losses;
    logic       w_enter_win;
    logic       w_enter_lose;

    assign w_enter_win  = (w_state_next == WIN)  && (r_state != WIN);
    assign w_enter_lose = (w_state_next == LOSE) && (r_state != LOSE);

    // Session tallies count entries into WIN and LOSE, saturating at 255.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wins   <= '0;
            r_losses <= '0;
        end else begin
            if (w_enter_win && (r_wins != 8'hFF)) begin
                r_wins <= r_wins + 8'd1;
            end
            if (w_enter_lose && (r_losses != 8'hFF)) begin
                r_losses <= r_losses + 8'd1;
            end
        end
    end

    assign o_wins   = r_wins;
    assign o_losses = r_losses;
`else
    assign o_wins   = 8'd0;
    assign o_losses = 8'd0;
`endif

endmodule

// File: tb/tb_craps_ctrl.sv
// Directed self-checking bench for craps_ctrl.
// Inputs change on the falling clock edge and outputs are compared on the
// falling edge after the rising edge that should have updated them.
// Expected tallies depend on whether CRAPS_STATS_EN is defined.
module tb_craps_ctrl;

   logic       clock;
   logic       reset;
   logic [2:0] dieA;
   logic [2:0] dieB;
   logic       choose;
   logic       newGame;
   logic       win;
   logic       lose;
   logic [3:0] point;
   logic [3:0] lastSum;
   logic [3:0] rolls;
   logic [7:0] wins;
   logic [7:0] losses;

   int checkCount = 0;
   int failCount  = 0;

   craps_ctrl #(.CNT_W(4)) dut (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_die_a    (dieA),
      .i_die_b    (dieB),
      .i_choose   (choose),
      .i_new_game (newGame),
      .o_win      (win),
      .o_lose     (lose),
      .o_point    (point),
      .o_last_sum (lastSum),
      .o_rolls    (rolls),
      .o_wins     (wins),
      .o_losses   (losses)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected session tally: the count when stats are built, zero otherwise.
   function automatic int tally(input int n);
`ifdef CRAPS_STATS_EN
      return n;
`else
      return 0;
`endif
   endfunction

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One complete roll: choose rises with the given dice, then drops.
   task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b);
      @(negedge clock);
      dieA   = a;
      dieB   = b;
      choose = 1'b1;
      @(negedge clock);
      choose = 1'b0;
      dieA   = 3'd0;
      dieB   = 3'd0;
   endtask

   // Single-cycle new_game pulse.
   task automatic pulseNewGame();
      @(negedge clock);
      newGame = 1'b1;
      @(negedge clock);
      newGame = 1'b0;
   endtask

   // Check the round outputs in one go.
   task automatic checkRound(input string tag, input int expWin, input int expLose,
                             input int expPoint, input int expSum, input int expRolls);
      checkOutput({tag, ".win"},     int'(win),     expWin);
      checkOutput({tag, ".lose"},    int'(lose),    expLose);
      checkOutput({tag, ".point"},   int'(point),   expPoint);
      checkOutput({tag, ".lastSum"}, int'(lastSum), expSum);
      checkOutput({tag, ".rolls"},   int'(rolls),   expRolls);
   endtask

   // Main directed sequence.
   initial begin
      reset   = 1'b1;
      dieA    = 3'd0;
      dieB    = 3'd0;
      choose  = 1'b0;
      newGame = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      checkRound("reset", 0, 0, 0, 0, 0);
      checkOutput("reset.wins",   int'(wins),   0);
      checkOutput("reset.losses", int'(losses), 0);

      // Natural 7 on come-out.
      applyStimulus(3'd3, 3'd4);
      checkRound("natural7", 1, 0, 0, 7, 1);
      checkOutput("natural7.wins", int'(wins), tally(1));

      // Rolls after WIN are ignored.
      applyStimulus(3'd2, 3'd2);
      checkRound("winFrozen", 1, 0, 0, 7, 1);

      pulseNewGame();
      checkRound("newGame1", 0, 0, 0, 0, 0);
      checkOutput("newGame1.wins", int'(wins), tally(1));

      // Craps 2 on come-out.
      applyStimulus(3'd1, 3'd1);
      checkRound("craps2", 0, 1, 0, 2, 1);
      checkOutput("craps2.losses", int'(losses), tally(1));

      // Point 6, miss with 10, make it with 6, then frozen.
      pulseNewGame();
      applyStimulus(3'd2, 3'd4);
      checkRound("point6", 0, 0, 6, 6, 1);
      applyStimulus(3'd5, 3'd5);
      checkRound("point6miss", 0, 0, 6, 10, 2);
      applyStimulus(3'd3, 3'd3);
      checkRound("point6made", 1, 0, 6, 6, 3);
      applyStimulus(3'd6, 3'd1);
      checkRound("point6frozen", 1, 0, 6, 6, 3);
      checkOutput("point6.wins", int'(wins), tally(2));

      // Point 8, seven-out, then new game keeps tallies.
      pulseNewGame();
      applyStimulus(3'd4, 3'd4);
      checkRound("point8", 0, 0, 8, 8, 1);
      applyStimulus(3'd3, 3'd4);
      checkRound("sevenOut", 0, 1, 8, 7, 2);
      pulseNewGame();
      checkRound("newGame2", 0, 0, 0, 0, 0);
      checkOutput("newGame2.losses", int'(losses), tally(2));
      checkOutput("newGame2.wins",   int'(wins),   tally(2));

      // Illegal faces are ignored.
      applyStimulus(3'd0, 3'd5);
      checkRound("dieAzero", 0, 0, 0, 0, 0);
      applyStimulus(3'd3, 3'd7);
      checkRound("dieBseven", 0, 0, 0, 0, 0);

      // choose held high for ten cycles counts once.
      @(negedge clock);
      dieA   = 3'd2;
      dieB   = 3'd3;
      choose = 1'b1;
      repeat (10) @(negedge clock);
      checkRound("chooseHeld", 0, 0, 5, 5, 1);
      choose = 1'b0;
      @(negedge clock);

      // new_game on the same cycle choose rises: roll discarded.
      @(negedge clock);
      newGame = 1'b1;
      dieA    = 3'd5;
      dieB    = 3'd6;
      choose  = 1'b1;
      @(negedge clock);
      newGame = 1'b0;
      repeat (2) @(negedge clock);
      checkRound("newGameCollide", 0, 0, 0, 0, 0);
      choose = 1'b0;
      @(negedge clock);

      // Roll counter saturates at 15 while chasing point 4.
      applyStimulus(3'd2, 3'd2);
      for (int i = 0; i < 15; i++) applyStimulus(3'd5, 3'd5);
      checkRound("rollsSat", 0, 0, 4, 10, 15);

      // Craps 12 on come-out, then natural 11.
      pulseNewGame();
      applyStimulus(3'd6, 3'd6);
      checkRound("craps12", 0, 1, 0, 12, 1);
      checkOutput("craps12.losses", int'(losses), tally(3));
      pulseNewGame();
      applyStimulus(3'd5, 3'd6);
      checkRound("natural11", 1, 0, 0, 11, 1);
      checkOutput("natural11.wins", int'(wins), tally(3));

      // Reset with choose already high: no roll, tallies cleared.
      @(negedge clock);
      dieA   = 3'd3;
      dieB   = 3'd4;
      choose = 1'b1;
      reset  = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checkRound("resetChooseHigh", 0, 0, 0, 0, 0);
      checkOutput("resetChooseHigh.wins",   int'(wins),   0);
      checkOutput("resetChooseHigh.losses", int'(losses), 0);
      choose = 1'b0;
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
